// File: rtl/cla4_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit CLA slice per cycle, valid/ready on both sides.
// Optional signed-overflow output enabled by defining CLA4_SERIAL_OVF_EN.

module b_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      s    = p ^ c[3:0];
      co   = c[4];
   end
endmodule

module cla4_serial_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef CLA4_SERIAL_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             carry_q;
   logic             cout_q;
   logic [IW-1:0]    idx;
   logic [IW+1:0]    base;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       s_nib;
   logic             co_nib;
   logic             accept;
   logic             run;
   logic             last;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (last)     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      run       = (state == RUN);
      accept    = in_ready & in_valid;
      last      = run & (idx == LAST);
   end

   always_comb begin
      base  = {idx, 2'b00};
      a_nib = 4'(a_q >> base);
      b_nib = 4'(b_q >> base);
      // Merge the new nibble; unwritten bits keep their previous value.
      sum_d = (sum_q & ~(WIDTH'(4'hF) << base)) | (WIDTH'(s_nib) << base);
   end

   b_cla4 u_slice (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry_q),
      .s  (s_nib),
      .co (co_nib)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx     <= '0;
      end else begin
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
         end
         if (run) begin
            sum_q   <= sum_d;
            carry_q <= co_nib;
            idx     <= idx + 1'b1;
            if (last) cout_q <= co_nib;
         end
      end
   end

`ifdef CLA4_SERIAL_OVF_EN
   logic ovf_q;
   // Carry into the MSB is recovered from the top slice's bit 3.
   always_ff @(posedge clk) begin
      if (!rst_n)    ovf_q <= 1'b0;
      else if (last) ovf_q <= (a_nib[3] ^ b_nib[3] ^ s_nib[3]) ^ co_nib;
   end
   assign ovf = ovf_q;
`endif

   assign sum  = sum_q;
   assign cout = cout_q;
endmodule
